// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Sequencing controller for the IF/ID/EXE/WB pipeline. Each
//                cycle it decides whether the ID instruction issues, stalls
//                or is flushed. It drives the PC, IF/ID and ID/EXE controls.
//                A shift-register scoreboard of pending writes in EXE and WB
//                detects RAW hazards. There is no forwarding, so a consumer
//                waits until its producer has left WB.
//  Ports       : clk, rst               - clock, synchronous active-high reset
//                id_*                   - instruction currently in ID
//                ext_hold               - front-end freeze request
//                flush_req              - taken branch, kill IF and ID
//                pc_en/ifid_en/ifid_flush/idex_bubble/issue - pipe controls
//                hazard                 - RAW hazard seen this cycle
//                state_o                - 0 RUN, 1 STALL, 2 FLUSH
//                stall_cnt              - saturating hold/hazard cycle count
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int RAW   = 5,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RAW-1:0]   id_rs1,
  input  logic             id_rs1_used,
  input  logic [RAW-1:0]   id_rs2,
  input  logic             id_rs2_used,
  input  logic [RAW-1:0]   id_rd,
  input  logic             id_wen,
  input  logic             ext_hold,
  input  logic             flush_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             issue,
  output logic             hazard,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0]       S_RUN    = 2'd0;
  localparam logic [1:0]       S_STALL  = 2'd1;
  localparam logic [1:0]       S_FLUSH  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [RAW-1:0]   REG_ZERO = '0;

  logic [1:0]                state_q, state_d;
  logic [DEPTH-1:0]          sb_v_q, sb_v_d;
  logic [DEPTH-1:0][RAW-1:0] sb_rd_q, sb_rd_d;
  logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

  logic rs1_hit;
  logic rs2_hit;
  logic raw_hit;
  logic bubble_cycle;

  // RAW detection against the registered scoreboard only. The ID
  // instruction's own destination is not in the scoreboard yet, so an
  // instruction reading its own rd is compared against older writers only.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb_v_q[k] && (sb_rd_q[k] == id_rs1)) rs1_hit = 1'b1;
      if (sb_v_q[k] && (sb_rd_q[k] == id_rs2)) rs2_hit = 1'b1;
    end
    raw_hit = id_valid && !flush_req &&
              ((id_rs1_used && (id_rs1 != REG_ZERO) && rs1_hit) ||
               (id_rs2_used && (id_rs2 != REG_ZERO) && rs2_hit));
  end

  // Next-state: the state records only the class of the current cycle.
  always_comb begin
    state_d = S_RUN;
    if (rst)                       state_d = S_RUN;
    else if (flush_req)            state_d = S_FLUSH;
    else if (ext_hold || raw_hit)  state_d = S_STALL;
  end

  // Mealy control outputs, priority rst > flush > hold > hazard > normal.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = !id_valid;
    issue        = id_valid;
    hazard       = 1'b0;
    bubble_cycle = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      issue       = 1'b0;
    end else if (flush_req) begin
      // Fetch continues from the branch target; IF and ID are killed.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      issue       = 1'b0;
    end else if (ext_hold || raw_hit) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_bubble  = 1'b1;
      issue        = 1'b0;
      hazard       = raw_hit;
      bubble_cycle = 1'b1;
    end else begin
      hazard = 1'b0;
    end
    if (!rst && ext_hold && !flush_req) hazard = raw_hit;
  end

  // Scoreboard and counter next values. The scoreboard shifts every
  // non-reset cycle: the back end always drains, even while ID is frozen.
  always_comb begin
    sb_v_d      = '0;
    sb_rd_d     = '0;
    stall_cnt_d = '0;
    if (!rst) begin
      sb_v_d[0]  = issue && id_wen && (id_rd != REG_ZERO);
      sb_rd_d[0] = id_rd;
      for (int k = 1; k < DEPTH; k++) begin
        sb_v_d[k]  = sb_v_q[k-1];
        sb_rd_d[k] = sb_rd_q[k-1];
      end
      stall_cnt_d = stall_cnt_q;
      if (bubble_cycle && (stall_cnt_q != CNT_MAX))
        stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    sb_v_q      <= sb_v_d;
    sb_rd_q     <= sb_rd_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign state_o   = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl. Two instances share
//                stimulus: one with the default 16-bit counter and one with a
//                4-bit counter for saturation. Expected values come from a
//                reference model that keeps a list of in-flight writes with
//                their remaining lifetime in the back end.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int RAW   = 5;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, id_valid, id_rs1_used, id_rs2_used, id_wen;
  logic           ext_hold, flush_req;
  logic [RAW-1:0] id_rs1, id_rs2, id_rd;

  logic        pc_en, ifid_en, ifid_flush, idex_bubble, issue, hazard;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt;

  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_issue, s_hazard;
  logic [1:0]  s_state_o;
  logic [3:0]  s_stall_cnt;

  pipe_hazard_ctrl #(.RAW(RAW), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wen(id_wen), .ext_hold(ext_hold), .flush_req(flush_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .issue(issue), .hazard(hazard),
    .state_o(state_o), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.RAW(RAW), .DEPTH(DEPTH), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wen(id_wen), .ext_hold(ext_hold), .flush_req(flush_req),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .issue(s_issue), .hazard(s_hazard),
    .state_o(s_state_o), .stall_cnt(s_stall_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: in-flight writes with cycles left before leaving WB.
  int pend_rd[$];
  int pend_life[$];
  int m_state  = 0;
  int m_cnt16  = 0;
  int m_cnt4   = 0;
  bit m_known  = 1'b0;

  // Observed values of the last step, for directed checks.
  logic o_haz, o_issue, o_pc, o_ifl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [RAW-1:0] rs1, input logic u1,
                      input logic [RAW-1:0] rs2, input logic u2,
                      input logic [RAW-1:0] rd, input logic w,
                      input logic hold, input logic fl);
    logic m_haz;
    logic e_pc, e_en, e_fl, e_bub, e_iss;
    int   nr[$];
    int   nl[$];
    rst = r; id_valid = v; id_rs1 = rs1; id_rs1_used = u1;
    id_rs2 = rs2; id_rs2_used = u2; id_rd = rd; id_wen = w;
    ext_hold = hold; flush_req = fl;
    #1;
    m_haz = 1'b0;
    if (!r && v && !fl) begin
      foreach (pend_rd[i]) begin
        if (u1 && rs1 != 0 && pend_rd[i] == int'(rs1)) m_haz = 1'b1;
        if (u2 && rs2 != 0 && pend_rd[i] == int'(rs2)) m_haz = 1'b1;
      end
    end
    if (r)                  {e_pc, e_en, e_fl, e_bub, e_iss} = 5'b00110;
    else if (fl)            {e_pc, e_en, e_fl, e_bub, e_iss} = 5'b11110;
    else if (hold || m_haz) {e_pc, e_en, e_fl, e_bub, e_iss} = 5'b00010;
    else                    {e_pc, e_en, e_fl, e_bub, e_iss} = {3'b110, !v, v};
    chk("pc_en",       pc_en,       e_pc);
    chk("ifid_en",     ifid_en,     e_en);
    chk("ifid_flush",  ifid_flush,  e_fl);
    chk("idex_bubble", idex_bubble, e_bub);
    chk("issue",       issue,       e_iss);
    chk("hazard",      hazard,      m_haz);
    chk("sat_hazard",  s_hazard,    m_haz);
    if (m_known) begin
      chk("state_o",   state_o,     m_state);
      chk("stall_cnt", stall_cnt,   m_cnt16);
      chk("sat_cnt",   s_stall_cnt, m_cnt4);
    end
    o_haz = hazard; o_issue = issue; o_pc = pc_en; o_ifl = ifid_flush;
    @(posedge clk);
    if (r) begin
      pend_rd.delete(); pend_life.delete();
      m_state = 0; m_cnt16 = 0; m_cnt4 = 0; m_known = 1'b1;
    end else begin
      foreach (pend_rd[i]) begin
        if (pend_life[i] > 1) begin
          nr.push_back(pend_rd[i]);
          nl.push_back(pend_life[i] - 1);
        end
      end
      if (e_iss && w && rd != 0) begin
        nr.push_back(int'(rd));
        nl.push_back(DEPTH);
      end
      pend_rd = nr; pend_life = nl;
      m_state = fl ? 2 : ((hold || m_haz) ? 1 : 0);
      if (!fl && (hold || m_haz)) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15)     m_cnt4++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic instr(input logic [RAW-1:0] rs1, input logic u1,
                       input logic [RAW-1:0] rs2, input logic u2,
                       input logic [RAW-1:0] rd, input logic w);
    step(0, 1, rs1, u1, rs2, u2, rd, w, 0, 0);
  endtask

  initial begin
    int nh;
    // Reset for two cycles, then idle.
    do_reset();
    do_reset();
    chk("rst_ifid_flush", o_ifl, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_state", state_o, 2'd0);
    chk("post_rst_cnt", stall_cnt, 16'd0);
    chk("post_rst_issue", o_issue, 1'b0);

    // Back-to-back RAW on rs1.
    do_reset();
    instr(0, 0, 0, 0, 3, 1);
    nh = 0;
    repeat (3) begin
      instr(3, 1, 0, 0, 0, 0);
      nh += int'(o_haz);
    end
    chk("b2b_stalls", nh, 2);
    chk("b2b_issue", o_issue, 1'b1);
    chk("b2b_cnt", stall_cnt, 16'd2);

    // Distance-2 RAW on rs2.
    do_reset();
    instr(0, 0, 0, 0, 7, 1);
    instr(2, 1, 0, 0, 1, 1);
    nh = 0;
    repeat (2) begin
      instr(0, 0, 7, 1, 0, 0);
      nh += int'(o_haz);
    end
    chk("dist2_stalls", nh, 1);
    chk("dist2_issue", o_issue, 1'b1);
    // Register 0 never hazards.
    instr(0, 0, 0, 0, 0, 1);
    instr(0, 1, 0, 1, 4, 1);
    chk("r0_hazard", o_haz, 1'b0);
    chk("r0_issue", o_issue, 1'b1);

    // Flush in the first stall cycle of a hazard.
    do_reset();
    instr(0, 0, 0, 0, 3, 1);
    step(0, 1, 3, 1, 0, 0, 0, 0, 0, 1);
    chk("flush_hazard", o_haz, 1'b0);
    chk("flush_pc_en", o_pc, 1'b1);
    chk("flush_ifid_flush", o_ifl, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_state", state_o, 2'd0);
    chk("flush_cnt", stall_cnt, 16'd0);

    // Hold with an in-flight write to r5, then the consumer is released.
    do_reset();
    instr(0, 0, 0, 0, 5, 1);
    repeat (4) step(0, 1, 5, 1, 0, 0, 0, 0, 1, 0);
    chk("hold_state", state_o, 2'd1);
    instr(5, 1, 0, 0, 0, 0);
    chk("hold_rel_hazard", o_haz, 1'b0);
    chk("hold_rel_issue", o_issue, 1'b1);
    chk("hold_cnt", stall_cnt, 16'd4);

    // Saturation of the narrow counter, then reset mid-hold.
    do_reset();
    repeat (20) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("sat_stop", s_stall_cnt, 4'd15);
    chk("wide_cnt", stall_cnt, 16'd20);
    instr(0, 0, 0, 0, 6, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_sat_cnt", s_stall_cnt, 4'd0);
    chk("rst_state", state_o, 2'd0);
    instr(6, 1, 0, 0, 0, 0);
    chk("rst_sb_clear", o_haz, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           RAW'($urandom_range(0, 7)), 1'($urandom),
           RAW'($urandom_range(0, 7)), 1'($urandom),
           RAW'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
